z_core_inst_encoder: RTL and testbench

Streaming RV32I instruction encoder: accepts decoded instruction fields (format, opcode, register indices, funct3/funct7, full-width immediate) and packs them into 32-bit machine words. It is the inverse of `z_core_decoder`, and field placement is bit-exact with it. It is used by the test-program generator and the self-check path, feeding packed words into instruction memory or comparing them against the decoder. Input and output both use valid/ready handshakes, with a 2-entry output buffer between them.

---
 rtl/z_core_pkg.sv | 24 ++
 rtl/z_core_inst_encoder_if.sv | 33 +++
 rtl/z_core_enc_pack.sv | 51 +++++
 rtl/z_core_inst_encoder.sv | 74 +++++++
 tb/tb_z_core_inst_encoder.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/z_core_pkg.sv
// Shared RV32I constants and types for the z_core encoder and decoder.
package z_core_pkg;

   typedef enum logic [2:0] {
      FMT_R = 3'd0,
      FMT_I = 3'd1,
      FMT_S = 3'd2,
      FMT_B = 3'd3,
      FMT_U = 3'd4,
      FMT_J = 3'd5
   } fmt_e;

   localparam logic [6:0] OP_LUI    = 7'h37;
   localparam logic [6:0] OP_JAL    = 7'h6F;
   localparam logic [6:0] OP_BRANCH = 7'h63;
   localparam logic [6:0] OP_STORE  = 7'h23;
   localparam logic [6:0] OP_IMM    = 7'h13;

   typedef struct packed {
      logic [31:0] inst;
      logic        err;
   } enc_entry_t;

endpackage

// File: rtl/z_core_inst_encoder_if.sv
// Field-bundle input and packed-word output handshakes of the instruction encoder.
interface z_core_inst_encoder_if;

   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_fmt;
   logic [6:0]  in_op;
   logic [4:0]  in_rd;
   logic [4:0]  in_rs1;
   logic [4:0]  in_rs2;
   logic [2:0]  in_funct3;
   logic [6:0]  in_funct7;
   logic [31:0] in_imm;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_inst;
   logic        out_err;

   // Encoder side.
   modport slave (
      input  in_valid, in_fmt, in_op, in_rd, in_rs1, in_rs2,
             in_funct3, in_funct7, in_imm, out_ready,
      output in_ready, out_valid, out_inst, out_err
   );

   // Producer / consumer side.
   modport master (
      output in_valid, in_fmt, in_op, in_rd, in_rs1, in_rs2,
             in_funct3, in_funct7, in_imm, out_ready,
      input  in_ready, out_valid, out_inst, out_err
   );

endinterface

// File: rtl/z_core_enc_pack.sv
// Combinational RV32I field packer; immediate range check enabled by Z_ENC_RANGE_CHECK_EN.
module z_core_enc_pack
   import z_core_pkg::*;
(
   input  logic [2:0]  fmt,
   input  logic [6:0]  op,
   input  logic [4:0]  rd,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [2:0]  funct3,
   input  logic [6:0]  funct7,
   input  logic [31:0] imm,
   output logic [31:0] inst,
   output logic        err
);

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      inst = '0;
      case (fmt)
         FMT_R:   inst = {funct7, rs2, rs1, funct3, rd, op};
         FMT_I:   inst = {imm[11:0], rs1, funct3, rd, op};
         FMT_S:   inst = {imm[11:5], rs2, rs1, funct3, imm[4:0], op};
         FMT_B:   inst = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op};
         FMT_U:   inst = {imm[31:12], rd, op};
         FMT_J:   inst = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
         default: inst = '0;
      endcase
   end

`ifdef Z_ENC_RANGE_CHECK_EN
   logic signed [31:0] simm;
   assign simm = imm;

   // Flag words whose immediate does not survive truncation into the field.
   always_comb begin
      err = 1'b0;
      case (fmt)
         FMT_R:        err = 1'b0;
         FMT_I, FMT_S: err = (simm < -32'sd2048) || (simm > 32'sd2047);
         FMT_B:        err = (simm < -32'sd4096) || (simm > 32'sd4094) || imm[0];
         FMT_J:        err = (simm < -32'sd1048576) || (simm > 32'sd1048574) || imm[0];
         FMT_U:        err = (imm[11:0] != 12'd0);
         default:      err = 1'b1;
      endcase
   end
`else
   assign err = 1'b0;
`endif

endmodule

// File: rtl/z_core_inst_encoder.sv
// Streaming RV32I encoder: packer feeding a 2-entry output FIFO and a delivered-word counter.
// Optional immediate range checking is enabled by defining Z_ENC_RANGE_CHECK_EN.
module z_core_inst_encoder
   import z_core_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   z_core_inst_encoder_if.slave  bus,
   output logic [15:0]           enc_count
);

   localparam logic [1:0] FULL = 2'(DEPTH);

   enc_entry_t  mem [2];
   enc_entry_t  new_entry;
   enc_entry_t  head;
   logic        wr_ptr;
   logic        rd_ptr;
   logic [1:0]  count;
   logic        push;
   logic        pop;

   z_core_enc_pack u_pack (
      .fmt    (bus.in_fmt),
      .op     (bus.in_op),
      .rd     (bus.in_rd),
      .rs1    (bus.in_rs1),
      .rs2    (bus.in_rs2),
      .funct3 (bus.in_funct3),
      .funct7 (bus.in_funct7),
      .imm    (bus.in_imm),
      .inst   (new_entry.inst),
      .err    (new_entry.err)
   );

   assign bus.in_ready  = (count != FULL);
   assign bus.out_valid = (count != 2'd0);
   assign push          = bus.in_valid && bus.in_ready;
   assign pop           = bus.out_valid && bus.out_ready;

   // Storage is not reset, so the head is masked while empty to give zero outputs after reset.
   assign head         = mem[rd_ptr];
   assign bus.out_inst = bus.out_valid ? head.inst : 32'd0;
   assign bus.out_err  = bus.out_valid ? head.err  : 1'b0;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr    <= 1'b0;
         rd_ptr    <= 1'b0;
         count     <= 2'd0;
         enc_count <= 16'd0;
      end else begin
         if (push) wr_ptr <= ~wr_ptr;
         if (pop) begin
            rd_ptr    <= ~rd_ptr;
            enc_count <= enc_count + 16'd1;
         end
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   // NOTE: the data array has no reset; validity is tracked by count, which is reset.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= new_entry;
   end

endmodule

// File: tb/tb_z_core_inst_encoder.sv
// Directed self-checking bench for z_core_inst_encoder; expectations follow Z_ENC_RANGE_CHECK_EN.
module tb_z_core_inst_encoder;
   import z_core_pkg::*;

`ifdef Z_ENC_RANGE_CHECK_EN
   localparam logic EXP_RC = 1'b1;
`else
   localparam logic EXP_RC = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] enc_count;
   int          n_assert = 0;
   int          n_fail   = 0;

   z_core_inst_encoder_if bus_if ();

   z_core_inst_encoder dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus_if),
      .enc_count (enc_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Inputs change and outputs are sampled 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] imm);
      bus_if.in_valid  = 1'b1;
      bus_if.in_fmt    = fmt;
      bus_if.in_op     = op;
      bus_if.in_rd     = rd;
      bus_if.in_rs1    = rs1;
      bus_if.in_rs2    = rs2;
      bus_if.in_funct3 = f3;
      bus_if.in_funct7 = f7;
      bus_if.in_imm    = imm;
   endtask

   initial begin
      bus_if.out_ready = 1'b0;
      drive(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
      bus_if.in_valid = 1'b0;

      // Reset state
      #3;
      check("rst_out_valid", 32'(bus_if.out_valid), 32'd0);
      check("rst_out_inst", bus_if.out_inst, 32'd0);
      check("rst_out_err", 32'(bus_if.out_err), 32'd0);
      check("rst_enc_count", 32'(enc_count), 32'd0);
      tick();
      rst = 1'b0;
      check("rst_in_ready", 32'(bus_if.in_ready), 32'd1);

      // S pack, visible one cycle after accept
      drive(FMT_S, OP_STORE, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd16);
      tick();
      bus_if.in_valid = 1'b0;
      check("s_valid", 32'(bus_if.out_valid), 32'd1);
      check("s_inst", bus_if.out_inst, 32'h0020_8823);
      check("s_err", 32'(bus_if.out_err), 32'd0);
      bus_if.out_ready = 1'b1;
      tick();
      check("s_popped", 32'(bus_if.out_valid), 32'd0);
      check("s_count", 32'(enc_count), 32'd1);

      // I/U/J/B back-to-back
      drive(FMT_I, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
      tick();
      check("addi", bus_if.out_inst, 32'h0050_0093);
      drive(FMT_U, OP_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
      tick();
      check("lui", bus_if.out_inst, 32'h1234_52B7);
      drive(FMT_J, OP_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8);
      tick();
      check("jal", bus_if.out_inst, 32'h0080_00EF);
      drive(FMT_B, OP_BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8);
      tick();
      check("beq", bus_if.out_inst, 32'h0020_8463);
      check("beq_valid", 32'(bus_if.out_valid), 32'd1);
      bus_if.in_valid = 1'b0;
      tick();
      check("stream_empty", 32'(bus_if.out_valid), 32'd0);
      check("stream_count", 32'(enc_count), 32'd5);  // 1 from the S word + 4

      // Backpressure: three offered, two accepted
      bus_if.out_ready = 1'b0;
      drive(FMT_I, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
      tick();
      drive(FMT_I, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2);
      check("bp_ready1", 32'(bus_if.in_ready), 32'd1);
      tick();
      check("bp_full", 32'(bus_if.in_ready), 32'd0);
      check("bp_head_a", bus_if.out_inst, 32'h0010_0093);
      drive(FMT_I, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
      tick();
      check("bp_still_full", 32'(bus_if.in_ready), 32'd0);
      check("bp_stable", bus_if.out_inst, 32'h0010_0093);
      bus_if.out_ready = 1'b1;
      tick();
      check("bp_ready_back", 32'(bus_if.in_ready), 32'd1);
      check("bp_head_b", bus_if.out_inst, 32'h0020_0093);
      tick();
      bus_if.in_valid = 1'b0;
      check("bp_head_c", bus_if.out_inst, 32'h0030_0093);
      tick();
      check("bp_empty", 32'(bus_if.out_valid), 32'd0);
      check("bp_count", 32'(enc_count), 32'd8);

      // Range-check boundaries
      drive(FMT_I, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
      tick();
      check("rc_i_imm", 32'(bus_if.out_inst[31:20]), 32'h800);
      check("rc_i_err", 32'(bus_if.out_err), 32'(EXP_RC));
      drive(FMT_B, OP_BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd7);
      tick();
      check("rc_b_inst", bus_if.out_inst, 32'h0020_8363);
      check("rc_b_err", 32'(bus_if.out_err), 32'(EXP_RC));
      drive(3'd7, OP_IMM, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0);
      tick();
      check("rc_fmt7_inst", bus_if.out_inst, 32'd0);
      check("rc_fmt7_err", 32'(bus_if.out_err), 32'(EXP_RC));
      bus_if.in_valid = 1'b0;
      tick();
      check("rc_count", 32'(enc_count), 32'd11);

      // Asynchronous reset with two words buffered
      bus_if.out_ready = 1'b0;
      drive(FMT_I, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
      tick();
      tick();
      bus_if.in_valid = 1'b0;
      check("mid_full", 32'(bus_if.in_ready), 32'd0);
      #2;
      rst = 1'b1;
      #1;
      check("mid_rst_valid", 32'(bus_if.out_valid), 32'd0);
      check("mid_rst_count", 32'(enc_count), 32'd0);
      check("mid_rst_inst", bus_if.out_inst, 32'd0);
      tick();
      rst = 1'b0;
      bus_if.out_ready = 1'b1;
      drive(FMT_U, OP_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
      tick();
      bus_if.in_valid = 1'b0;
      check("post_rst_inst", bus_if.out_inst, 32'h1234_52B7);
      tick();
      check("post_rst_count", 32'(enc_count), 32'd1);

      // Counter wrap: after k edges of full-rate streaming enc_count = k-1
      rst = 1'b1;
      tick();
      rst = 1'b0;
      drive(FMT_I, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
      for (int i = 0; i < 65536; i++) tick();
      check("wrap_ffff", 32'(enc_count), 32'h0000_FFFF);
      tick();
      check("wrap_0000", 32'(enc_count), 32'h0000_0000);
      tick();
      check("wrap_0001", 32'(enc_count), 32'h0000_0001);
      bus_if.in_valid = 1'b0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
